// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out receiver.
//   state_t      : receiver FSM state encoding
//   BITS_DEFAULT : default frame length in bits
package sipo_pkg;

    localparam int unsigned BITS_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : sipo_pkg

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out frame receiver with a one-word hold register.
// Frames arrive MSB first, one bit per sen strobe; eos marks the last bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   sin, sen   : serial data bit and its strobe
//   eos        : end-of-shift marker, qualified by sen
//   ack        : consumer acknowledge of the held word
//   dout       : last good received word
//   dvalid     : dout holds an unacknowledged word
//   busy       : frame partially received
//   ferr       : one-cycle framing-error pulse
//   ovr        : sticky overrun flag, cleared by ack
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int unsigned BITS = BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sin,
    input  logic            sen,
    input  logic            eos,
    input  logic            ack,
    output logic [BITS-1:0] dout,
    output logic            dvalid,
    output logic            busy,
    output logic            ferr,
    output logic            ovr
);

    localparam int unsigned     CW   = $clog2(BITS);
    localparam logic [CW-1:0]   LAST = CW'(BITS - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] sreg;

    logic            last_c;
    logic            done_c;
    logic            err_c;
    logic            take_c;
    logic [BITS-1:0] word_c;

    // Frame completion / error decode for the current strobe
    always_comb begin
        last_c = (cnt == LAST);
        word_c = {sreg[BITS-2:0], sin};
        done_c = 1'b0;
        err_c  = 1'b0;
        if (sen) begin
            if (state == IDLE) begin
                err_c = eos;
            end else begin
                done_c = eos && last_c;
                // eos early, or last bit without eos
                err_c  = (eos != last_c);
            end
        end
        take_c = done_c && (!dvalid || ack);
    end

    // Receiver FSM, shift register and output hold register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sreg   <= '0;
            dout   <= '0;
            dvalid <= 1'b0;
            busy   <= 1'b0;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            ferr <= err_c;

            if (sen) begin
                case (state)
                    IDLE: begin
                        if (!eos) begin
                            sreg  <= BITS'(sin);
                            cnt   <= CW'(1);
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (done_c || err_c) begin
                            sreg  <= '0;
                            cnt   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            sreg <= word_c;
                            cnt  <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end

            if (take_c) begin
                dout   <= word_c;
                dvalid <= 1'b1;
            end else if (ack) begin
                dvalid <= 1'b0;
            end

            // A completion blocked by an unacknowledged word sets overrun
            if (done_c && !take_c) begin
                ovr <= 1'b1;
            end else if (ack) begin
                ovr <= 1'b0;
            end
        end
    end

endmodule : sipo_rx

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: table of frames plus hand-written
// reset-mid-frame sequence; received words checked through a scoreboard.
module tb_sipo_rx;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         sin;
    logic         sen;
    logic         eos;
    logic         ack;
    logic [W-1:0] dout;
    logic         dvalid;
    logic         busy;
    logic         ferr;
    logic         ovr;

    sipo_rx #(.BITS(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sin    (sin),
        .sen    (sen),
        .eos    (eos),
        .ack    (ack),
        .dout   (dout),
        .dvalid (dvalid),
        .busy   (busy),
        .ferr   (ferr),
        .ovr    (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ferr_hi = 0;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] prev_dout = '0;
    logic         prev_dv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: counts ferr cycles and pops the scoreboard on each new word
    always @(negedge clk) begin
        if (ferr) ferr_hi++;
        if (dvalid && (!prev_dv || dout != prev_dout)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_word", 32'(dout), 32'hFFFF_FFFF);
            end else begin
                chk("sb_word", 32'(dout), 32'(sb_q.pop_front()));
            end
        end
        prev_dv   = dvalid;
        prev_dout = dout;
    end

    // One clock cycle of stimulus, starting and ending just after a negedge
    task automatic cyc(input logic s, input logic b, input logic e, input logic a);
        sen = s; sin = b; eos = e; ack = a;
        @(negedge clk);
        #1;
        sen = 1'b0; sin = 1'b0; eos = 1'b0; ack = 1'b0;
    endtask

    // eos_at: bit number (1..W) carrying eos; 0 means no eos at all
    task automatic send_frame(input logic [W-1:0] w, input int gap, input int eos_at,
                              input logic ack_last, input logic push);
        int  n;
        logic bad;
        n   = (eos_at == 0) ? W : eos_at;
        bad = (eos_at != W);
        if (push) sb_q.push_back(w);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, w[W-1-i], (i + 1 == eos_at), (i == W - 1) ? ack_last : 1'b0);
            chk("busy_bit", 32'(busy), 32'(i + 1 < n));
            chk("ferr_bit", 32'(ferr), 32'(bad && (i + 1 == n)));
            if (i + 1 < n) begin
                for (int g = 0; g < gap; g++) begin
                    cyc(1'b0, 1'b1, 1'b1, 1'b0);
                    chk("busy_gap", 32'(busy), 32'd1);
                end
            end
        end
    endtask

    typedef struct {
        logic [W-1:0] word;
        int           gap;
        int           eos_at;
        logic         ack_last;
        logic         ack_after;
        logic         push;
        logic [W-1:0] exp_dout;
        logic         exp_dvalid;
        logic         exp_ovr;
        int           exp_ferr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{8'hA5, 0, 8, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 0};
        tbl[1]  = '{8'h3C, 2, 8, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 0};
        tbl[2]  = '{8'hA5, 0, 5, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1};
        tbl[3]  = '{8'h81, 0, 8, 1'b0, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1};
        tbl[4]  = '{8'h11, 0, 8, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1};
        tbl[5]  = '{8'h22, 0, 8, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1};
        tbl[6]  = '{8'h11, 0, 8, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1};
        tbl[7]  = '{8'h22, 0, 8, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1};
        tbl[8]  = '{8'hC3, 1, 0, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 2};
        tbl[9]  = '{8'h80, 0, 1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 3};
        tbl[10] = '{8'hFF, 0, 8, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 3};
        tbl[11] = '{8'h00, 1, 8, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 3};

        rst_n = 1'b0; sin = 1'b0; sen = 1'b0; eos = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dvalid", 32'(dvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ferr", 32'(ferr), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        rst_n = 1'b1;
        #1;

        // Stray ack with nothing held is ignored
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ack_idle_dvalid", 32'(dvalid), 32'd0);

        for (int r = 0; r < 12; r++) begin
            send_frame(tbl[r].word, tbl[r].gap, tbl[r].eos_at, tbl[r].ack_last, tbl[r].push);
            chk("row_dout", 32'(dout), 32'(tbl[r].exp_dout));
            chk("row_dvalid", 32'(dvalid), 32'(tbl[r].exp_dvalid));
            chk("row_ovr", 32'(ovr), 32'(tbl[r].exp_ovr));
            chk("row_ferr_total", 32'(ferr_hi), 32'(tbl[r].exp_ferr));
            chk("row_busy", 32'(busy), 32'd0);
            if (tbl[r].ack_after) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b1);
                chk("ack_dvalid", 32'(dvalid), 32'd0);
                chk("ack_ovr", 32'(ovr), 32'd0);
                chk("ack_dout_hold", 32'(dout), 32'(tbl[r].exp_dout));
            end
        end

        // Build up a held word and an overrun, then reset in the middle of a frame
        send_frame(8'h11, 0, 8, 1'b0, 1'b1);
        send_frame(8'h22, 0, 8, 1'b0, 1'b0);
        chk("pre_rst_ovr", 32'(ovr), 32'd1);
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] f0;
            f0 = 8'hF0;
            cyc(1'b1, f0[W-1-i], 1'b0, 1'b0);
        end
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #2;
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_dvalid", 32'(dvalid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ovr", 32'(ovr), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        send_frame(8'h5A, 0, 8, 1'b0, 1'b1);
        chk("post_rst_dout", 32'(dout), 32'h5A);
        chk("post_rst_dvalid", 32'(dvalid), 32'd1);
        chk("post_rst_ferr_total", 32'(ferr_hi), 32'd3);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sipo_rx

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 SHALL have parameter BITS, default 8, giving frame length in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port sin  input  1  serial data bit, MSB of the frame first.
REQ-005 SHALL have port sen  input  1  bit strobe; sin and eos are sampled only when sen=1.
REQ-006 SHALL have port eos  input  1  end-of-shift marker; high together with the last bit of a frame.
REQ-007 SHALL have port ack  input  1  consumer acknowledge of the held word.
REQ-008 SHALL have port dout  output  BITS  last good received word.
REQ-009 SHALL have port dvalid  output  1  dout holds an unacknowledged word.
REQ-010 SHALL have port busy  output  1  high while a frame is partially received (state SHIFT).
REQ-011 SHALL have port ferr  output  1  one-cycle pulse on a framing error.
REQ-012 SHALL have port ovr  output  1  sticky overrun flag.

Function
REQ-013 SHALL use FSM states IDLE and SHIFT, plus a bit counter of width clog2(BITS) and a BITS-wide shift register.
REQ-014 In IDLE with sen=1 and eos=0, the FSM SHALL load sin into the shift register LSB, set the counter to 1 and go to SHIFT.
REQ-015 In IDLE with sen=1 and eos=1, the FSM SHALL pulse ferr, discard the bit and stay in IDLE.
REQ-016 In SHIFT with sen=1, the shift register SHALL shift left with sin entering the LSB, and the counter SHALL increment.
REQ-017 In SHIFT, sen=1 with eos=1 and counter=BITS-1 SHALL complete the frame and return to IDLE.
REQ-018 In SHIFT, sen=1 with eos=1 and counter<BITS-1 SHALL pulse ferr, discard the partial frame and return to IDLE.
REQ-019 In SHIFT, sen=1 with eos=0 and counter=BITS-1 SHALL pulse ferr, discard the frame and return to IDLE.
REQ-020 With sen=0 the shift register, counter and state SHALL hold; there is no timeout.
REQ-021 On completion with dvalid=0 or ack=1, dout SHALL take the assembled word (last bit included) and dvalid=1, registered at the edge that samples the last bit.
REQ-022 On completion with dvalid=1 and ack=0, dout and dvalid SHALL be unchanged and ovr SHALL set.
REQ-023 ack=1 without completion SHALL clear dvalid on the next edge; ack while dvalid=0 SHALL be ignored.
REQ-024 ack=1 SHALL clear ovr, unless a same-cycle completion sets it (set wins).
REQ-025 busy SHALL be 1 exactly when the state is SHIFT.
REQ-026 ferr SHALL be registered and high for exactly one cycle per error.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, counter 0, shift register 0, dout 0, dvalid 0, busy 0, ferr 0 and ovr 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first sen after release is treated as bit 0 of a new frame.

Structure
REQ-029 The FSM state encoding and the BITS default SHALL live in shared package sipo_pkg.
REQ-030 The block SHALL be a single module with no sub-modules; the paired transmitter's eos and Q connect directly to eos and sin.

Verification
REQ-031 Send 0xA5 MSB-first over 8 consecutive sen cycles with eos on bit 8 -> dout=0xA5, dvalid=1 the cycle after bit 8, ferr never high.
REQ-032 Send 0x3C with 2 idle (sen=0) cycles between each bit -> dout=0x3C; busy high from after bit 1 until after bit 8.
REQ-033 Assert eos on bit 5 -> one ferr pulse, dvalid stays 0, busy=0; a following good 0x81 -> dout=0x81.
REQ-034 Send 0x11 without ack, then 0x22 -> dout=0x11, ovr=1; then ack -> dvalid=0, ovr=0.
REQ-035 Send 0x11, then 0x22 with ack high in the last-bit cycle -> dout=0x22, dvalid=1, ovr=0.
REQ-036 Pulse rst_n low after bit 4 of 0xF0, then send 0x5A -> dout=0x5A, ferr never high.
